// File: rtl/video_rd_addr_gen.sv
// Purpose : per-read-port frame fetch address generator; walks a frame line by line as burst read commands.
// Latency : vsync rise sampled at N -> first command valid at N+1; one command per cycle while ready.
// Backpr. : a presented command holds addr/len until accepted; cmd_valid stays high until the frame completes.
//
// Ports:
//   pclk, rst         - pixel clock, synchronous active-high reset
//   vsync, base       - frame sync (rising edge starts a frame), frame base address sampled on that edge
//   cmd_valid/ready   - command handshake towards the memory arbiter
//   cmd_addr, cmd_len - command start word address and length (1..BURST)
//   frame_busy        - high while commands of a frame are being issued
//   frame_done        - one-cycle pulse after the last command of a frame is accepted
//   overrun           - one-cycle pulse when vsync rises while a frame is still being issued
module video_rd_addr_gen #(
    parameter int ASIZE      = 28,
    parameter int LINE_WORDS = 20,
    parameter int HEIGHT     = 10,
    parameter int BURST      = 8,
    parameter int STRIDE     = 32
) (
    input  logic                         pclk,
    input  logic                         rst,
    input  logic                         vsync,
    input  logic [ASIZE-1:0]             base,
    output logic                         cmd_valid,
    input  logic                         cmd_ready,
    output logic [ASIZE-1:0]             cmd_addr,
    output logic [$clog2(BURST+1)-1:0]   cmd_len,
    output logic                         frame_busy,
    output logic                         frame_done,
    output logic                         overrun
);

    localparam int LENW = $clog2(BURST + 1);
    localparam int OFFW = $clog2(LINE_WORDS + 1);
    localparam int CNTW = $clog2(HEIGHT + 1);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DONE} state_t;

    state_t             r_state;
    logic               r_vs_d;
    logic [ASIZE-1:0]   r_line_addr;
    logic [OFFW-1:0]    r_word_off;
    logic [CNTW-1:0]    r_line_cnt;
    logic [ASIZE-1:0]   r_pend_base;
    logic               r_restart;
    logic               r_cmd_valid;
    logic [ASIZE-1:0]   r_cmd_addr;
    logic [LENW-1:0]    r_cmd_len;
    logic               r_frame_busy;
    logic               r_frame_done;
    logic               r_overrun;

    logic               w_vs_rise;
    logic               w_hs;
    logic [OFFW-1:0]    w_next_off;
    logic               w_line_end;
    logic               w_last_line;
    logic [ASIZE-1:0]   w_restart_base;
    logic [ASIZE-1:0]   w_next_line;

    // Words left in the line, capped at one burst; commands never cross a line end.
    function automatic logic [LENW-1:0] f_len(input logic [OFFW-1:0] off);
        int rem;
        rem = LINE_WORDS - int'(off);
        if (rem > BURST) f_len = LENW'(BURST);
        else             f_len = LENW'(rem);
    endfunction

    assign w_vs_rise   = vsync & ~r_vs_d;
    assign w_hs        = r_cmd_valid & cmd_ready;
    assign w_next_off  = r_word_off + OFFW'(r_cmd_len);
    assign w_line_end  = (w_next_off == OFFW'(LINE_WORDS));
    assign w_last_line = (r_line_cnt == CNTW'(HEIGHT - 1));
    assign w_next_line = r_line_addr + ASIZE'(STRIDE);
    // A vsync rise coinciding with the handshake is newer than any pending base.
    assign w_restart_base = w_vs_rise ? base : r_pend_base;

    always_ff @(posedge pclk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_vs_d       <= 1'b1;   // vsync held high through reset must not start a frame
            r_line_addr  <= '0;
            r_word_off   <= '0;
            r_line_cnt   <= '0;
            r_pend_base  <= '0;
            r_restart    <= 1'b0;
            r_cmd_valid  <= 1'b0;
            r_cmd_addr   <= '0;
            r_cmd_len    <= '0;
            r_frame_busy <= 1'b0;
            r_frame_done <= 1'b0;
            r_overrun    <= 1'b0;
        end else begin
            r_vs_d       <= vsync;
            r_frame_done <= 1'b0;
            r_overrun    <= 1'b0;
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (w_vs_rise) begin
                        r_state      <= S_ISSUE;
                        r_line_addr  <= base;
                        r_word_off   <= '0;
                        r_line_cnt   <= '0;
                        r_restart    <= 1'b0;
                        r_cmd_valid  <= 1'b1;
                        r_cmd_addr   <= base;
                        r_cmd_len    <= f_len('0);
                        r_frame_busy <= 1'b1;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_ISSUE: begin
                    if (w_vs_rise) begin
                        r_pend_base <= base;
                        r_restart   <= 1'b1;
                        r_overrun   <= 1'b1;
                    end
                    if (w_hs) begin
                        if (w_vs_rise || r_restart) begin
                            // Abort: the accepted command was the old frame's last one.
                            r_restart   <= 1'b0;
                            r_line_addr <= w_restart_base;
                            r_word_off  <= '0;
                            r_line_cnt  <= '0;
                            r_cmd_addr  <= w_restart_base;
                            r_cmd_len   <= f_len('0);
                        end else if (w_line_end && w_last_line) begin
                            r_state      <= S_DONE;
                            r_cmd_valid  <= 1'b0;
                            r_frame_busy <= 1'b0;
                            r_frame_done <= 1'b1;
                        end else if (w_line_end) begin
                            r_word_off  <= '0;
                            r_line_cnt  <= r_line_cnt + CNTW'(1);
                            r_line_addr <= w_next_line;
                            r_cmd_addr  <= w_next_line;
                            r_cmd_len   <= f_len('0);
                        end else begin
                            r_word_off  <= w_next_off;
                            r_cmd_addr  <= r_line_addr + ASIZE'(w_next_off);
                            r_cmd_len   <= f_len(w_next_off);
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign cmd_valid  = r_cmd_valid;
    assign cmd_addr   = r_cmd_addr;
    assign cmd_len    = r_cmd_len;
    assign frame_busy = r_frame_busy;
    assign frame_done = r_frame_done;
    assign overrun    = r_overrun;

endmodule

// File: tb/tb_video_rd_addr_gen.sv
// Purpose : directed bench for video_rd_addr_gen with default parameters.
// Latency : outputs sampled 1 time unit after each rising pclk edge.
// Backpr. : cmd_ready driven constant-high, random, or held low per sequence.
module tb_video_rd_addr_gen;

    logic        pclk;
    logic        rst;
    logic        vsync;
    logic [27:0] base;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [27:0] cmd_addr;
    logic [3:0]  cmd_len;
    logic        frame_busy;
    logic        frame_done;
    logic        overrun;

    int n_chk = 0;
    int n_err = 0;

    video_rd_addr_gen dut (
        .pclk       (pclk),
        .rst        (rst),
        .vsync      (vsync),
        .base       (base),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_addr   (cmd_addr),
        .cmd_len    (cmd_len),
        .frame_busy (frame_busy),
        .frame_done (frame_done),
        .overrun    (overrun)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    typedef struct {
        logic        vs;
        logic        rdy;
        logic [27:0] b;
        logic        e_vld;
        logic [27:0] e_addr;
        logic [3:0]  e_len;
        logic        e_busy;
        logic        e_done;
        logic        e_ovr;
    } vec_t;

    vec_t tv [6];

    task automatic step();
        @(posedge pclk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Expected command i of a frame: 3 commands per line (8, 8, 4 words), lines 32 words apart.
    function automatic logic [27:0] m_addr(input logic [27:0] b, input int i);
        m_addr = b + 28'((i / 3) * 32 + (i % 3) * 8);
    endfunction

    function automatic logic [3:0] m_len(input int i);
        m_len = ((i % 3) == 2) ? 4'd4 : 4'd8;
    endfunction

    task automatic start_frame(input logic [27:0] b);
        vsync     = 1'b1;
        base      = b;
        cmd_ready = 1'b0;
        step();
        vsync = 1'b0;
        chk("start_vld",  {31'd0, cmd_valid}, 32'd1);
        chk("start_addr", {4'd0, cmd_addr}, {4'd0, b});
        chk("start_len",  {28'd0, cmd_len}, 32'd8);
    endtask

    // Drive the frame from command start_idx (currently presented) to frame_done.
    task automatic run_frame(input logic [27:0] b, input int start_idx, input bit rnd,
                             input bit chain, input logic [27:0] nbase);
        int          idx;
        bit          done, hs_prev, prev_stall, saw_ovr, vdrop, rdy;
        logic [27:0] pa;
        logic [3:0]  pl;
        idx = start_idx; done = 0; hs_prev = 0; prev_stall = 0; saw_ovr = 0; vdrop = 0;
        pa = '0; pl = '0;
        for (int cyc = 0; cyc < 1000 && !done; cyc++) begin
            if (prev_stall) begin
                chk("hold_addr", {4'd0, cmd_addr}, {4'd0, pa});
                chk("hold_len",  {28'd0, cmd_len}, {28'd0, pl});
            end
            if (!cmd_valid) vdrop = 1;
            rdy = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            cmd_ready = rdy;
            hs_prev = cmd_valid && rdy;
            if (hs_prev) begin
                chk($sformatf("cmd%0d_addr", idx), {4'd0, cmd_addr}, {4'd0, m_addr(b, idx)});
                chk($sformatf("cmd%0d_len", idx),  {28'd0, cmd_len}, {28'd0, m_len(idx)});
                idx++;
            end
            prev_stall = cmd_valid && !rdy;
            pa = cmd_addr;
            pl = cmd_len;
            step();
            if (overrun)    saw_ovr = 1;
            if (frame_done) done = 1;
        end
        chk("frame_done_seen", {31'd0, done}, 32'd1);
        chk("cmd_count",       idx, 32'd30);
        chk("done_latency",    {31'd0, hs_prev}, 32'd1);
        chk("done_vld_low",    {31'd0, cmd_valid}, 32'd0);
        chk("no_overrun",      {31'd0, saw_ovr}, 32'd0);
        chk("valid_no_drop",   {31'd0, vdrop}, 32'd0);
        if (chain) begin
            vsync = 1'b1;
            base  = nbase;
            step();
            vsync = 1'b0;
            chk("b2b_vld",  {31'd0, cmd_valid}, 32'd1);
            chk("b2b_addr", {4'd0, cmd_addr}, {4'd0, nbase});
            chk("b2b_ovr",  {31'd0, overrun}, 32'd0);
            chk("b2b_done_pulse", {31'd0, frame_done}, 32'd0);
        end else begin
            step();
            chk("done_pulse", {31'd0, frame_done}, 32'd0);
            chk("idle_vld",   {31'd0, cmd_valid}, 32'd0);
            chk("idle_busy",  {31'd0, frame_busy}, 32'd0);
        end
    endtask

    initial begin
        //         vs    rdy   base      vld   addr      len  busy  done  ovr
        tv[0] = '{1'b0, 1'b0, 28'h1000, 1'b0, 28'h0,    4'd0, 1'b0, 1'b0, 1'b0};
        tv[1] = '{1'b1, 1'b0, 28'h1000, 1'b1, 28'h1000, 4'd8, 1'b1, 1'b0, 1'b0};
        tv[2] = '{1'b1, 1'b1, 28'h1000, 1'b1, 28'h1008, 4'd8, 1'b1, 1'b0, 1'b0};
        tv[3] = '{1'b0, 1'b0, 28'h1000, 1'b1, 28'h1008, 4'd8, 1'b1, 1'b0, 1'b0};
        tv[4] = '{1'b0, 1'b1, 28'h1000, 1'b1, 28'h1010, 4'd4, 1'b1, 1'b0, 1'b0};
        tv[5] = '{1'b0, 1'b1, 28'h1000, 1'b1, 28'h1020, 4'd8, 1'b1, 1'b0, 1'b0};

        rst = 1'b1; vsync = 1'b0; cmd_ready = 1'b0; base = '0;
        repeat (3) step();
        chk("rst_vld",  {31'd0, cmd_valid}, 32'd0);
        chk("rst_addr", {4'd0, cmd_addr}, 32'd0);
        chk("rst_len",  {28'd0, cmd_len}, 32'd0);
        chk("rst_busy", {31'd0, frame_busy}, 32'd0);
        chk("rst_done", {31'd0, frame_done}, 32'd0);
        chk("rst_ovr",  {31'd0, overrun}, 32'd0);
        rst = 1'b0;

        // Nominal frame: cycle-exact start from the table, remainder by model.
        for (int i = 0; i < 6; i++) begin
            vsync = tv[i].vs; cmd_ready = tv[i].rdy; base = tv[i].b;
            step();
            chk($sformatf("v%0d_vld", i),  {31'd0, cmd_valid}, {31'd0, tv[i].e_vld});
            chk($sformatf("v%0d_addr", i), {4'd0, cmd_addr}, {4'd0, tv[i].e_addr});
            chk($sformatf("v%0d_len", i),  {28'd0, cmd_len}, {28'd0, tv[i].e_len});
            chk($sformatf("v%0d_busy", i), {31'd0, frame_busy}, {31'd0, tv[i].e_busy});
            chk($sformatf("v%0d_done", i), {31'd0, frame_done}, {31'd0, tv[i].e_done});
            chk($sformatf("v%0d_ovr", i),  {31'd0, overrun}, {31'd0, tv[i].e_ovr});
        end
        vsync = 1'b0;
        run_frame(28'h1000, 3, 0, 0, 28'h0);

        // Backpressure: random ready, same command sequence.
        start_frame(28'h1000);
        run_frame(28'h1000, 0, 1, 0, 28'h0);

        // Overrun at the 5th command while stalled.
        start_frame(28'h1000);
        cmd_ready = 1'b1;
        repeat (4) step();
        chk("ovr_pre_addr", {4'd0, cmd_addr}, 32'h1028);
        cmd_ready = 1'b0; vsync = 1'b1; base = 28'h2000;
        step();
        vsync = 1'b0; base = 28'h5555;
        chk("ovr_pulse",     {31'd0, overrun}, 32'd1);
        chk("ovr_hold_vld",  {31'd0, cmd_valid}, 32'd1);
        chk("ovr_hold_addr", {4'd0, cmd_addr}, 32'h1028);
        chk("ovr_hold_len",  {28'd0, cmd_len}, 32'd8);
        step();
        chk("ovr_once",      {31'd0, overrun}, 32'd0);
        chk("ovr_hold2_addr", {4'd0, cmd_addr}, 32'h1028);
        cmd_ready = 1'b1;
        step();
        chk("ovr_new_addr", {4'd0, cmd_addr}, 32'h2000);
        chk("ovr_new_len",  {28'd0, cmd_len}, 32'd8);
        chk("ovr_no_done",  {31'd0, frame_done}, 32'd0);
        // The 0x2000 frame ends with vsync rising in its DONE cycle (back-to-back).
        run_frame(28'h2000, 0, 0, 1, 28'h4000);
        run_frame(28'h4000, 0, 0, 0, 28'h0);

        // Address wrap at 2^28.
        start_frame(28'hFFFFFF0);
        cmd_ready = 1'b1;
        step();
        chk("wrap_a1", {4'd0, cmd_addr}, 32'h0FFFFFF8);
        step();
        chk("wrap_a2", {4'd0, cmd_addr}, 32'h0000000);
        chk("wrap_l2", {28'd0, cmd_len}, 32'd4);
        step();
        chk("wrap_line1", {4'd0, cmd_addr}, 32'h0000010);
        run_frame(28'hFFFFFF0, 3, 0, 0, 28'h0);

        // Reset mid-line 3 with vsync held high through release.
        start_frame(28'h1000);
        cmd_ready = 1'b1;
        repeat (10) step();
        chk("rst_mid_addr", {4'd0, cmd_addr}, 32'h1068);
        rst = 1'b1; vsync = 1'b1;
        step();
        chk("mrst_vld",  {31'd0, cmd_valid}, 32'd0);
        chk("mrst_addr", {4'd0, cmd_addr}, 32'd0);
        chk("mrst_len",  {28'd0, cmd_len}, 32'd0);
        chk("mrst_busy", {31'd0, frame_busy}, 32'd0);
        chk("mrst_done", {31'd0, frame_done}, 32'd0);
        chk("mrst_ovr",  {31'd0, overrun}, 32'd0);
        step();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("post_rst_vld",  {31'd0, cmd_valid}, 32'd0);
            chk("post_rst_busy", {31'd0, frame_busy}, 32'd0);
            chk("post_rst_done", {31'd0, frame_done}, 32'd0);
        end
        vsync = 1'b0;
        step();
        chk("vs_low_vld", {31'd0, cmd_valid}, 32'd0);
        start_frame(28'h3000);
        run_frame(28'h3000, 0, 0, 0, 28'h0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
